// File: rtl/ps2_phy_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 physical layer.
//   ps2_state_t    : transceiver FSM states (encoding is visible on dbg_state)
//   PS2_FRAME_BITS : start + 8 data + parity + stop
//   PS2_CMD_*      : common host-to-keyboard command bytes
//   odd_parity     : parity bit that makes data plus parity hold an odd number of ones
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RX      = 3'd1,
        INHIBIT = 3'd2,
        RTS     = 3'd3,
        TX      = 3'd4,
        TXACK   = 3'd5,
        TXEND   = 3'd6
    } ps2_state_t;

    localparam int PS2_FRAME_BITS = 11;

    localparam logic [7:0] PS2_CMD_LEDS  = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET = 8'hFF;
    localparam logic [7:0] PS2_ACK       = 8'hFA;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_phy_if.sv
// ps2_phy_if: byte-level handshake between the PS/2 PHY and the protocol translator.
//   istrobe/ibyte : received byte and its one-cycle valid strobe (PHY -> translator)
//   oreq/obyte    : level transmit request and its byte (translator -> PHY)
//   oack/timeout  : one-cycle transfer results (PHY -> translator)
//   master = translator side, slave = PHY side.
interface ps2_phy_if;

    logic       istrobe;
    logic [7:0] ibyte;
    logic       oreq;
    logic [7:0] obyte;
    logic       oack;
    logic       timeout;

    modport master (
        output oreq, obyte,
        input  istrobe, ibyte, oack, timeout
    );

    modport slave (
        input  oreq, obyte,
        output istrobe, ibyte, oack, timeout
    );

endinterface

// File: rtl/ps2_phy_pin_filter.sv
// ps2_pin_filter: 2-flop synchroniser plus agreement filter for one PS/2 pin.
//   clk, reset : system clock, asynchronous active-high reset (presets output to 1)
//   pin        : raw asynchronous pin level
//   level      : filtered level; changes only after FILTER_LEN consecutive
//                synchronised samples disagree with it
module ps2_pin_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync  <= 2'b11;
            cnt   <= '0;
            level <= 1'b1;
        end else begin
            sync <= {sync[0], pin};
            if (sync[1] == level)
                cnt <= '0;
            else if (cnt == CW'(FILTER_LEN - 1)) begin
                level <= sync[1];
                cnt   <= '0;
            end else
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_phy.sv
// ps2_phy: PS/2 physical-layer transceiver (device-to-host receive, host-to-device send).
//   clk, reset     : system clock, asynchronous active-high reset
//   ps2clk, ps2dat : open-drain connector pins, only ever pulled low or released
//   host           : byte handshake to the protocol translator (ps2_phy_if.slave)
//   dbg_state      : current FSM state encoding
module ps2_phy
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int INHIBIT_CYC = 3200,
    parameter int TIMEOUT_CYC = 480000
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire        ps2clk,
    inout  wire        ps2dat,
    ps2_phy_if.slave   host,
    output logic [2:0] dbg_state
);

    localparam logic [19:0] TOUT_LOAD = 20'(TIMEOUT_CYC - 1);
    localparam logic [19:0] INH_LOAD  = 20'(INHIBIT_CYC - 1);
    localparam logic [3:0]  LAST_BIT  = 4'(PS2_FRAME_BITS - 2);

    ps2_state_t  state, state_n;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic [9:0]  sh, sh_n, rx_word;
    logic [19:0] cnt, cnt_n;
    logic        clk_oe, clk_oe_n, dat_oe, dat_oe_n;
    logic        istrobe, istrobe_n, oack, oack_n, timeout, timeout_n;
    logic [7:0]  ibyte, ibyte_n;
    logic        clk_f, clk_prev, clk_fall, dat_f, counting;

    ps2_pin_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk(clk), .reset(reset), .pin(ps2clk), .level(clk_f)
    );

    ps2_pin_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clk(clk), .reset(reset), .pin(ps2dat), .level(dat_f)
    );

    assign clk_fall = clk_prev & ~clk_f;
    // sh is shared: RX shifts in at the top, TX shifts out of bit 0 with 1s filling in
    assign rx_word  = {dat_f, sh[9:1]};
    assign counting = state inside {RX, RTS, TX, TXACK, TXEND};

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        sh_n      = sh;
        clk_oe_n  = clk_oe;
        dat_oe_n  = dat_oe;
        cnt_n     = counting ? (clk_fall ? TOUT_LOAD : cnt - 1'b1) : cnt;
        istrobe_n = 1'b0;
        ibyte_n   = ibyte;
        oack_n    = 1'b0;
        timeout_n = 1'b0;
        case (state)
            IDLE: begin
                if (clk_fall && !dat_f) begin
                    state_n   = RX;
                    bit_cnt_n = '0;
                    cnt_n     = TOUT_LOAD;
                // oack still high means the translator has not yet seen it and dropped oreq
                end else if (!clk_fall && host.oreq && !oack) begin
                    state_n  = INHIBIT;
                    sh_n     = {1'b1, odd_parity(host.obyte), host.obyte};
                    clk_oe_n = 1'b1;
                    cnt_n    = INH_LOAD;
                end
            end
            RX: begin
                if (clk_fall) begin
                    sh_n      = rx_word;
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == LAST_BIT) begin
                        state_n = IDLE;
                        if (rx_word[9] && ^rx_word[8:0]) begin
                            istrobe_n = 1'b1;
                            ibyte_n   = rx_word[7:0];
                        end
                    end
                end
            end
            INHIBIT: begin
                if (cnt == '0) begin
                    state_n  = RTS;
                    clk_oe_n = 1'b0;
                    dat_oe_n = 1'b1;
                    cnt_n    = TOUT_LOAD;
                end else
                    cnt_n = cnt - 1'b1;
            end
            RTS, TX: begin
                // the first device falling edge presents d0; the stop bit (a release) is the last
                if (clk_fall) begin
                    dat_oe_n  = ~sh[0];
                    sh_n      = {1'b1, sh[9:1]};
                    bit_cnt_n = (state == RTS) ? 4'd1 : bit_cnt + 4'd1;
                    state_n   = (state == TX && bit_cnt == LAST_BIT) ? TXACK : TX;
                end
            end
            TXACK: begin
                if (clk_fall) begin
                    state_n   = dat_f ? IDLE : TXEND;
                    timeout_n = dat_f;
                    clk_oe_n  = 1'b0;
                    dat_oe_n  = 1'b0;
                end
            end
            TXEND: begin
                if (clk_f && dat_f) begin
                    state_n = IDLE;
                    oack_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (counting && !clk_fall && cnt == '0) begin
            state_n   = IDLE;
            clk_oe_n  = 1'b0;
            dat_oe_n  = 1'b0;
            istrobe_n = 1'b0;
            ibyte_n   = ibyte;
            oack_n    = 1'b0;
            timeout_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            sh       <= '0;
            cnt      <= '0;
            clk_prev <= 1'b1;
            clk_oe   <= 1'b0;
            dat_oe   <= 1'b0;
            istrobe  <= 1'b0;
            ibyte    <= 8'h00;
            oack     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            sh       <= sh_n;
            cnt      <= cnt_n;
            clk_prev <= clk_f;
            clk_oe   <= clk_oe_n;
            dat_oe   <= dat_oe_n;
            istrobe  <= istrobe_n;
            ibyte    <= ibyte_n;
            oack     <= oack_n;
            timeout  <= timeout_n;
        end
    end

    assign ps2clk       = clk_oe ? 1'b0 : 1'bz;
    assign ps2dat       = dat_oe ? 1'b0 : 1'bz;
    assign host.istrobe = istrobe;
    assign host.ibyte   = ibyte;
    assign host.oack    = oack;
    assign host.timeout = timeout;
    assign dbg_state    = state;

endmodule

// File: tb/tb_ps2_phy.sv
// tb_ps2_phy: self-checking bench for ps2_phy with a behavioural PS/2 device model.
module tb_ps2_phy;
    import ps2_pkg::*;

    localparam int FL  = 4;
    localparam int INH = 64;
    localparam int TO  = 3000;
    localparam int HP  = 25;

    typedef struct {
        logic [7:0] b;
        bit         perr;
        bit         serr;
        bit         exp_strobe;
        logic [7:0] exp_byte;
    } rx_vec_t;

    typedef struct {
        logic [7:0] b;
        bit         ack;
    } tx_vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    wire        ps2clk;
    wire        ps2dat;
    logic [2:0] dbg_state;
    int         vectors = 0;
    int         miscompares = 0;
    int         n_strobe = 0, n_ack = 0, n_to = 0, n_excl = 0;
    logic [7:0] last_byte = 8'h00;
    logic [9:0] rx_bits;
    bit         rx_ok;

    ps2_phy_if host();

    pullup (ps2clk);
    pullup (ps2dat);
    assign ps2clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2dat = dev_dat_low ? 1'b0 : 1'bz;

    ps2_phy #(.FILTER_LEN(FL), .INHIBIT_CYC(INH), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .ps2clk(ps2clk), .ps2dat(ps2dat),
        .host(host), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (host.istrobe) begin
                n_strobe++;
                last_byte = host.ibyte;
            end
            if (host.oack) n_ack++;
            if (host.timeout) n_to++;
            if (int'(host.istrobe) + int'(host.oack) + int'(host.timeout) > 1) n_excl++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic par_of(input logic [7:0] b);
        return ($countones(b) % 2) == 0;
    endfunction

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit perr, input bit serr);
        return {~serr, par_of(b) ^ perr, b, 1'b0};
    endfunction

    // device-to-host: data changes while the clock is high, the host samples on the fall
    task automatic dev_send(input logic [10:0] fr, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            dev_dat_low = ~fr[i];
            wait_cyc(HP);
            dev_clk_low = 1'b1;
            wait_cyc(HP);
            dev_clk_low = 1'b0;
        end
        wait_cyc(HP);
        dev_dat_low = 1'b0;
    endtask

    // host-to-device: wait for inhibit then request-to-send, clock 10 bits in, then ACK
    task automatic dev_recv(input bit chk_inh, input bit ack);
        int n;
        rx_ok = 1'b0;
        rx_bits = '0;
        n = 0;
        while (ps2clk !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        if (ps2clk !== 1'b0) return;
        n = 0;
        while (ps2clk !== 1'b1 && n < 4 * INH) begin @(negedge clk); n++; end
        if (ps2clk !== 1'b1) return;
        if (chk_inh) check("inhibit_len_ok", 32'(n >= INH), 1);
        check("rts_dat_low", 32'(ps2dat), 0);
        wait_cyc(HP);
        for (int i = 0; i < 10; i++) begin
            dev_clk_low = 1'b1;
            wait_cyc(HP);
            dev_clk_low = 1'b0;
            wait_cyc(HP);
            rx_bits[i] = ps2dat;
        end
        dev_dat_low = ack;
        wait_cyc(HP / 2);
        dev_clk_low = 1'b1;
        wait_cyc(HP);
        dev_clk_low = 1'b0;
        wait_cyc(HP);
        dev_dat_low = 1'b0;
        rx_ok = 1'b1;
    endtask

    task automatic host_tx(input logic [7:0] b, input bit ack, input bit chk_inh);
        host.obyte = b;
        host.oreq = 1'b1;
        fork
            dev_recv(chk_inh, ack);
            begin
                int n = 0;
                while (!(host.oack || host.timeout) && n < 3 * TO) begin @(negedge clk); n++; end
                host.oreq = 1'b0;
            end
        join
    endtask

    rx_vec_t    rxv[6];
    tx_vec_t    txv[6];
    logic [7:0] model_byte;

    initial begin
        int s, t, a, n;
        bit perr, serr, valid;
        logic [7:0] b;
        rxv[0] = '{8'h1C, 1'b0, 1'b0, 1'b1, 8'h1C};
        rxv[1] = '{8'h5A, 1'b1, 1'b0, 1'b0, 8'h1C};
        rxv[2] = '{8'h00, 1'b0, 1'b0, 1'b1, 8'h00};
        rxv[3] = '{8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF};
        rxv[4] = '{8'hA5, 1'b0, 1'b1, 1'b0, 8'hFF};
        rxv[5] = '{PS2_ACK, 1'b0, 1'b0, 1'b1, PS2_ACK};
        txv[0] = '{PS2_CMD_LEDS, 1'b1};
        txv[1] = '{PS2_CMD_RESET, 1'b0};
        txv[2] = '{8'h00, 1'b1};
        for (int i = 3; i < 6; i++) txv[i] = '{8'($urandom), 1'b1};
        host.oreq = 1'b0;
        host.obyte = 8'h00;

        wait_cyc(5);
        check("rst_istrobe", 32'(host.istrobe), 0);
        check("rst_ibyte", 32'(host.ibyte), 0);
        check("rst_oack", 32'(host.oack), 0);
        check("rst_timeout", 32'(host.timeout), 0);
        check("rst_dbg_state", 32'(dbg_state), 0);
        check("rst_ps2clk", 32'(ps2clk), 1);
        check("rst_ps2dat", 32'(ps2dat), 1);
        reset = 1'b0;
        wait_cyc(20);

        foreach (rxv[i]) begin
            s = n_strobe;
            t = n_to;
            dev_send(mk_frame(rxv[i].b, rxv[i].perr, rxv[i].serr), 11);
            wait_cyc(20);
            check($sformatf("rx%0d_strobes", i), 32'(n_strobe - s), 32'(rxv[i].exp_strobe));
            check($sformatf("rx%0d_ibyte", i), 32'(host.ibyte), 32'(rxv[i].exp_byte));
            check($sformatf("rx%0d_timeouts", i), 32'(n_to - t), 0);
            check($sformatf("rx%0d_state", i), 32'(dbg_state), 0);
        end

        model_byte = rxv[5].exp_byte;
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            perr = ($urandom_range(0, 3) == 0);
            serr = ($urandom_range(0, 7) == 0);
            valid = !perr && !serr;
            if (valid) model_byte = b;
            s = n_strobe;
            dev_send(mk_frame(b, perr, serr), 11);
            wait_cyc(20);
            check($sformatf("rnd%0d_strobes", i), 32'(n_strobe - s), 32'(valid));
            check($sformatf("rnd%0d_ibyte", i), 32'(host.ibyte), 32'(model_byte));
        end

        foreach (txv[i]) begin
            a = n_ack;
            t = n_to;
            host_tx(txv[i].b, txv[i].ack, 1'b1);
            wait_cyc(10);
            check($sformatf("tx%0d_device_done", i), 32'(rx_ok), 1);
            check($sformatf("tx%0d_bits", i), 32'(rx_bits), 32'({1'b1, par_of(txv[i].b), txv[i].b}));
            check($sformatf("tx%0d_oacks", i), 32'(n_ack - a), 32'(txv[i].ack));
            check($sformatf("tx%0d_timeouts", i), 32'(n_to - t), 32'(!txv[i].ack));
            check($sformatf("tx%0d_state", i), 32'(dbg_state), 0);
            check($sformatf("tx%0d_clk_released", i), 32'(ps2clk), 1);
        end

        s = n_strobe;
        t = n_to;
        dev_send(mk_frame(8'h3A, 1'b0, 1'b0), 4);
        n = 2 * HP;
        while (n_to == t && n < TO + 200) begin @(negedge clk); n++; end
        wait_cyc(5);
        check("rxto_pulses", 32'(n_to - t), 1);
        check("rxto_latency_ok", 32'(n >= TO && n <= TO + 20), 1);
        check("rxto_strobes", 32'(n_strobe - s), 0);
        check("rxto_clk_released", 32'(ps2clk), 1);
        check("rxto_dat_released", 32'(ps2dat), 1);
        check("rxto_state", 32'(dbg_state), 0);

        s = n_strobe;
        a = n_ack;
        t = n_to;
        host.obyte = 8'h3C;
        fork
            begin
                dev_send(mk_frame(8'h77, 1'b0, 1'b0), 11);
                dev_recv(1'b0, 1'b1);
            end
            begin
                int m = 0;
                while (dut.clk_fall !== 1'b1 && m < 500) begin @(negedge clk); m++; end
                host.oreq = 1'b1;
                m = 0;
                while (!(host.oack || host.timeout) && m < 20000) begin @(negedge clk); m++; end
                n = n_strobe - s;
                host.oreq = 1'b0;
            end
        join
        wait_cyc(10);
        check("both_strobe_before_oack", 32'(n), 1);
        check("both_ibyte", 32'(last_byte), 32'h77);
        check("both_oacks", 32'(n_ack - a), 1);
        check("both_timeouts", 32'(n_to - t), 0);
        check("both_tx_bits", 32'(rx_bits), 32'({1'b1, par_of(8'h3C), 8'h3C}));

        host.obyte = PS2_CMD_RESET;
        host.oreq = 1'b1;
        n = 0;
        while (ps2clk !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        check("midrst_inhibit_seen", 32'(ps2clk), 0);
        #3;
        reset = 1'b1;
        host.oreq = 1'b0;
        #1;
        check("midrst_clk_released", 32'(ps2clk), 1);
        check("midrst_state", 32'(dbg_state), 0);
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(5);

        check("exclusive_pulses", 32'(n_excl), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
